// File: rtl/serial_adder_sched.sv
// serial_adder_sched: bit-serial add/subtract engine shared by two requesters.
// One full-adder cell is reused for WIDTH cycles per operation. Requesters are
// arbitrated round-robin, and results come back on one shared, ID-tagged channel.
module serial_adder_sched #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   shift_a, shift_b, acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               id;
    logic               rr_last;

    logic               grant;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               sel_sub;
    logic               bit_s, bit_c;
    logic               last;

    // Round-robin grant: a lone requester wins, a conflict goes to the one not served last.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid)
            grant = ~rr_last;
        req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
        req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;
        sel_a      = grant ? req1_a   : req0_a;
        sel_b      = grant ? req1_b   : req0_b;
        sel_sub    = grant ? req1_sub : req0_sub;
    end

    // Shared full-adder cell working on the low bits of the shift registers.
    always_comb begin
        bit_s = shift_a[0] ^ shift_b[0] ^ carry;
        bit_c = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
        last  = (cnt == CNT_W'(WIDTH - 1));
        busy  = (state != IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic: accept -> RUN for WIDTH cycles -> DONE until consumed.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (res_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, serial add, result registers and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a   <= '0;
            shift_b   <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            id        <= 1'b0;
            rr_last   <= 1'b1;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtract as A + ~B + 1: invert B and seed the carry with sub.
                        shift_a <= sel_a;
                        shift_b <= sel_b ^ {WIDTH{sel_sub}};
                        carry   <= sel_sub;
                        id      <= grant;
                        rr_last <= grant;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    carry   <= bit_c;
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    acc     <= {bit_s, acc[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        res_valid <= 1'b1;
                        res_sum   <= {bit_s, acc[WIDTH-1:1]};
                        res_cout  <= bit_c;
                        res_id    <= id;
                    end
                end
                DONE: begin
                    if (res_ready)
                        res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_sched.sv
// tb_serial_adder_sched: directed and randomized checks of serial_adder_sched
// against an arithmetic reference model.
module tb_serial_adder_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_id, busy;
    logic [W-1:0] res_sum;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_cout(res_cout), .res_id(res_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, sum}. Add carries out of bit W; subtract reports 1 when no borrow.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        int unsigned ai, bi;
        ai = a;
        bi = b;
        if (sub)
            return {(ai >= bi) ? 1'b1 : 1'b0, W'(ai - bi)};
        else
            return (W+1)'(ai + bi);
    endfunction

    // One operation from requester rid; hold>0 keeps res_ready low that many cycles in DONE.
    task automatic do_op(input logic rid, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input int hold);
        logic [W:0] e;
        int         edges;
        e = model(a, b, sub);
        @(negedge clk);
        res_ready = 1'b0;
        if (rid) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        #1;
        chk("grant_ready", 32'(rid ? req1_ready : req0_ready), 32'd1);
        chk("other_ready", 32'(rid ? req0_ready : req1_ready), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
        edges = 0;
        while (res_valid !== 1'b1 && edges < 3 * W) begin
            @(posedge clk);
            edges++;
            #1;
        end
        chk("latency", 32'(edges), 32'(W));
        chk("sum", 32'(res_sum), 32'(e[W-1:0]));
        chk("cout", 32'(res_cout), 32'(e[W]));
        chk("id", 32'(res_id), 32'(rid));
        chk("busy_done", 32'(busy), 32'd1);
        if (hold > 0) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_sum", 32'(res_sum), 32'(e[W-1:0]));
                chk("hold_id", 32'(res_id), 32'(rid));
                chk("hold_busy", 32'(busy), 32'd1);
                chk("hold_readys", 32'({req0_ready, req1_ready}), 32'd0);
            end
        end
        res_ready = 1'b1;
        #1;
        chk("readys_on_consume", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("valid_drop", 32'(res_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("sum_kept", 32'(res_sum), 32'(e[W-1:0]));
        if (hold > 0) begin
            chk("ready_after_idle", 32'(req0_ready | req1_ready), 32'd1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    initial begin
        logic [W+1:0] q[$];
        int           grants[$];
        logic [W+1:0] exp_r;
        int           overlap;
        int           stray;
        int           cyc;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        res_ready = 1'b0;
        #3;
        chk("rst_outputs", 32'({res_valid, res_sum, res_cout, res_id, busy,
                                req0_ready, req1_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || res_valid !== 1'b0) stray++;
        end
        chk("idle_quiet", 32'(stray), 32'd0);

        do_op(1'b0, 8'hFF, 8'h01, 1'b0, 0);
        do_op(1'b1, 8'h05, 8'h07, 1'b1, 0);
        do_op(1'b1, 8'h07, 8'h05, 1'b1, 0);
        do_op(1'b0, 8'h3C, 8'h5A, 1'b0, 5);
        repeat (10)
            do_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 0);
        do_op(1'b1, 8'h80, 8'h80, 1'b1, 0);
        do_op(1'b0, 8'h00, 8'h01, 1'b1, 0);
        do_op(1'b1, 8'hA5, 8'h00, 1'b0, 0);

        // Reset in the middle of a req1 operation.
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h11; req1_sub = 1'b1;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_outputs", 32'({res_valid, res_sum, res_cout, res_id, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (2 * W) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        chk("no_result_after_rst", 32'(stray), 32'd0);

        // Both requesters valid continuously with res_ready high.
        overlap = 0;
        res_ready = 1'b1;
        @(negedge clk);
        for (cyc = 0; cyc < 100; cyc++) begin
            if (grants.size() >= 4 && q.size() == 0 && res_valid !== 1'b1) break;
            if (grants.size() >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else begin
                req0_valid = 1'b1;
                req1_valid = 1'b1;
            end
            req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
            #1;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) overlap++;
            if (req0_ready === 1'b1) begin
                grants.push_back(0);
                q.push_back({1'b0, model(req0_a, req0_b, req0_sub)});
            end else if (req1_ready === 1'b1) begin
                grants.push_back(1);
                q.push_back({1'b1, model(req1_a, req1_b, req1_sub)});
            end
            if (res_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_r = q.pop_front();
                    chk("rr_result", 32'({res_id, res_cout, res_sum}), 32'(exp_r));
                end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b0;
        chk("rr_overlap", 32'(overlap), 32'd0);
        chk("rr_drained", 32'(q.size()), 32'd0);
        chk("rr_grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            chk("rr_g0", 32'(grants[0]), 32'd0);
            chk("rr_g1", 32'(grants[1]), 32'd1);
            chk("rr_g2", 32'(grants[2]), 32'd0);
            chk("rr_g3", 32'(grants[3]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
